// File: rtl/sevenseg_scan.sv
// Time-multiplexed 7-segment driver: frame-synchronous data commit, blanked digit slots,
// active-low anodes and segments. Define SEVENSEG_LZB_EN for leading-zero blanking.
module sevenseg_scan #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*NDIG-1:0]   data,
    input  logic [NDIG-1:0]     dpin,
    output logic [NDIG-1:0]     an,
    output logic [6:0]          seg,
    output logic                dp_n,
    output logic                busy,
    output logic                frame
);
    localparam int PW = $clog2(PRESCALE);
    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [PW-1:0]          pc;
    logic [DW-1:0]          dig;
    logic [NDIG-1:0][3:0]   disp, pend;
    logic [NDIG-1:0]        dispdp, penddp;
    logic                   pflag, bnd;
    logic                   slot_end, frame_end;
    logic [3:0]             nib;
    logic                   blank_slot, lz;

    assign slot_end  = (pc == PW'(PRESCALE - 1));
    assign frame_end = slot_end && (dig == DW'(NDIG - 1));

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    // Commit samples pend before this edge's LOAD lands, so a coincident LOAD stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            dig    <= '0;
            disp   <= '0;
            dispdp <= '0;
            pend   <= '0;
            penddp <= '0;
            pflag  <= 1'b0;
            bnd    <= 1'b0;
        end else begin
            pc  <= slot_end ? '0 : pc + 1'b1;
            bnd <= frame_end;
            if (slot_end)
                dig <= frame_end ? '0 : dig + 1'b1;
            if (frame_end && pflag) begin
                disp   <= pend;
                dispdp <= penddp;
            end
            if (load) begin
                pend   <= data;
                penddp <= dpin;
                pflag  <= 1'b1;
            end else if (frame_end) begin
                pflag  <= 1'b0;
            end
        end
    end

`ifdef SEVENSEG_LZB_EN
    logic [NDIG:0] zabove;
`endif

    always_comb begin
        nib        = disp[dig];
        blank_slot = (int'(pc) < BLANK);
        lz         = 1'b0;
`ifdef SEVENSEG_LZB_EN
        // zabove[k]: nibble k and every nibble above it are zero
        zabove       = '0;
        zabove[NDIG] = 1'b1;
        for (int k = NDIG - 1; k >= 0; k--)
            zabove[k] = zabove[k+1] && (disp[k] == 4'h0);
        lz = (dig != '0) && zabove[dig];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an    <= '1;
            seg   <= 7'h7F;
            dp_n  <= 1'b1;
            busy  <= 1'b0;
            frame <= 1'b0;
        end else begin
            busy  <= pflag;
            frame <= bnd;
            if (blank_slot) begin
                an   <= '1;
                seg  <= 7'h7F;
                dp_n <= 1'b1;
            end else begin
                an   <= ~(NDIG'(1) << dig);
                seg  <= lz ? 7'h7F : decode(nib);
                dp_n <= ~dispdp[dig];
            end
        end
    end
endmodule
